simon_control: RTL and testbench
================================

Name: simon_control

Overview:
- Control FSM that sequences the Simon datapath through four phases: pattern INPUT, PLAYBACK, REPEAT and DONE.
- Synchronises and edge-detects the player's "enter" button.
- Times the playback display and drives the datapath's write-enable, read-mux select, counter clear/increment strobes and mode LEDs.
- Sits between the top-level board I/O and the datapath; it is the only block that decides phase transitions.

Parameters:
- DISP_CYCLES, 4, clock cycles each stored entry is shown during PLAYBACK and DONE (≥1; board build uses 25_000_000).
- DEPTH, 64, pattern memory entries; maximum sequence length.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn  in  1  raw enter button, asynchronous level
- is_legal  in  1  datapath: current switch pattern is legal
- input_eq_pattern  in  1  datapath: switches equal memory read data
- play_last  in  1  datapath: playback index addresses the last stored entry
- rep_last  in  1  datapath: repeat index addresses the last stored entry
- done_last  in  1  datapath: done index addresses the last stored entry
- w_en  out  1  write switch pattern at count, then count+1
- clrcount  out  1  clear stored-entry count
- select  out  2  read-address mux: 00 playback, 01 repeat, 10 done
- play_clr, play_inc  out  1 each  playback index strobes
- rep_clr, rep_inc  out  1 each  repeat index strobes
- done_clr, done_inc  out  1 each  done index strobes
- mode_leds  out  3  001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE
- win  out  1  high in DONE when DEPTH entries were repeated correctly

Behaviour:
- rst (highest priority, sampled at posedge):
  - state←INPUT, timer←0, stored_cnt←0, win←0, sync flops←0.
  - While rst is high: clrcount=1, all other strobes 0, select=00, mode_leds=001.
- Button:
  - 3-flop shift s1→s2→s3; press = s2 & ~s3.
  - press is a one-cycle pulse in the cycle beginning at the 2nd posedge after btn rises.
  - Held button gives one pulse. Pulses not consumed by the current state are dropped, never queued.
- Strobes are Mealy outputs (state, press, status inputs, timer); state, timer, stored_cnt and win are registered.
- INPUT (mode 001, select 00):
  - press & is_legal & stored_cnt<DEPTH: w_en=1, play_clr=1, stored_cnt+1, next PLAYBACK, timer←0.
  - press & !is_legal: ignored.
  - stored_cnt==DEPTH: press ignored (unreachable in normal play; see REPEAT).
- PLAYBACK (mode 010, select 00):
  - timer counts 0..DISP_CYCLES-1.
  - At terminal with !play_last: play_inc=1, timer←0.
  - At terminal with play_last: rep_clr=1, next REPEAT.
  - press ignored.
- REPEAT (mode 100, select 01):
  - press & input_eq_pattern & !rep_last: rep_inc=1.
  - press & input_eq_pattern & rep_last & stored_cnt<DEPTH: next INPUT (new round).
  - press & input_eq_pattern & rep_last & stored_cnt==DEPTH: win←1, done_clr=1, next DONE.
  - press & !input_eq_pattern: done_clr=1, next DONE, win stays 0.
  - Legality is not checked in REPEAT.
- DONE (mode 111, select 10):
  - Timer as in PLAYBACK; at terminal: done_last ? done_clr : done_inc.
  - Sequence replays indefinitely; exits only via rst. press ignored.
- Timer width $clog2(DISP_CYCLES+1); it never exceeds DISP_CYCLES-1.
- stored_cnt width $clog2(DEPTH+1); it saturates at DEPTH.
- At most one of each clr/inc pair is high in any cycle.
- Reset mid-PLAYBACK or mid-REPEAT returns to INPUT next cycle with clrcount pulsed; no partial write.

Decomposition:
- simon_pkg holds:
  - state enum (S_INPUT, S_PLAYBACK, S_REPEAT, S_DONE)
  - MODE_INPUT/MODE_PLAYBACK/MODE_REPEAT/MODE_DONE (3-bit)
  - SEL_PLAYBACK/SEL_REPEAT/SEL_DONE (2-bit)
- Sub-module simon_btn_sync: 3-flop synchroniser plus rising-edge pulse, ports clk, rst, btn, press.

Test Plan:
- Reset, then btn pulse with is_legal=0 → no w_en, mode_leds stays 001. Then btn with is_legal=1 → exactly one w_en cycle, 2 cycles after btn rise, with play_clr that cycle; mode_leds=010 next cycle.
- PLAYBACK, DISP_CYCLES=4, play_last asserted after 2 play_inc → play_inc at cycles 4 and 8 after entry, rep_clr at cycle 12, mode_leds=100.
- REPEAT with input_eq_pattern=1: 3 presses, rep_last high on the 3rd → two rep_inc pulses, then back to INPUT (001), no done_clr.
- REPEAT press with input_eq_pattern=0 → done_clr, mode_leds=111, select=10, win=0. done_last every 3rd entry → done_inc,done_inc,done_clr repeating every 4 cycles.
- DEPTH=2: two full correct rounds → DONE with win=1. btn held high 20 cycles → exactly one press consumed.
- rst asserted mid-PLAYBACK → next cycle mode_leds=001, clrcount=1 during rst, no strobes. btn pressed during PLAYBACK → ignored, not replayed in REPEAT.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and encodings for the Simon control path: phase enum,
// mode LED patterns and read-address mux selects.
package simon_pkg;

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;

  localparam logic [1:0] SEL_PLAYBACK = 2'b00;
  localparam logic [1:0] SEL_REPEAT   = 2'b01;
  localparam logic [1:0] SEL_DONE     = 2'b10;

endpackage

// File: rtl/simon_btn_sync.sv
// Three-flop synchroniser for the raw enter button with a one-cycle
// rising-edge pulse taken between the second and third flops.
module simon_btn_sync
  import simon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may go metastable; only settled stages feed the edge detector.
  assign press = r_s2 & ~r_s3;

endmodule

// File: rtl/simon_control.sv
// Phase sequencer for the Simon datapath: INPUT -> PLAYBACK -> REPEAT,
// looping until a miss or a full-depth win lands in DONE.
module simon_control
  import simon_pkg::*;
#(
  parameter int DISP_CYCLES = 4,
  parameter int DEPTH       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       is_legal,
  input  logic       input_eq_pattern,
  input  logic       play_last,
  input  logic       rep_last,
  input  logic       done_last,
  output logic       w_en,
  output logic       clrcount,
  output logic [1:0] select,
  output logic       play_clr,
  output logic       play_inc,
  output logic       rep_clr,
  output logic       rep_inc,
  output logic       done_clr,
  output logic       done_inc,
  output logic [2:0] mode_leds,
  output logic       win
);

  localparam int TW = $clog2(DISP_CYCLES + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DISP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  state_e        r_state;
  state_e        w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_win;
  logic          w_win_next;
  logic          w_press;
  logic          w_term;
  logic          w_full;

  simon_btn_sync u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (w_press)
  );

  assign w_term = (r_timer == TIMER_LAST);
  assign w_full = (r_cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INPUT;
      r_timer <= '0;
      r_cnt   <= '0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_cnt   <= w_cnt_next;
      r_win   <= w_win_next;
    end
  end

  // The timer only runs in the display phases; elsewhere it parks at zero
  // so every PLAYBACK/DONE entry starts a fresh display slot.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = '0;
    w_cnt_next   = r_cnt;
    w_win_next   = r_win;
    case (r_state)
      S_INPUT: begin
        if (w_press && is_legal && !w_full) begin
          w_state_next = S_PLAYBACK;
          w_cnt_next   = r_cnt + CW'(1);
        end
      end
      S_PLAYBACK: begin
        if (w_term) begin
          if (play_last) w_state_next = S_REPEAT;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_REPEAT: begin
        if (w_press) begin
          if (!input_eq_pattern) begin
            w_state_next = S_DONE;
          end else if (rep_last) begin
            if (w_full) begin
              w_win_next   = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_INPUT;
            end
          end
        end
      end
      S_DONE: begin
        if (!w_term) w_timer_next = r_timer + TW'(1);
      end
      default: w_state_next = S_INPUT;
    endcase
  end

  always_comb begin
    w_en      = 1'b0;
    clrcount  = 1'b0;
    select    = SEL_PLAYBACK;
    play_clr  = 1'b0;
    play_inc  = 1'b0;
    rep_clr   = 1'b0;
    rep_inc   = 1'b0;
    done_clr  = 1'b0;
    done_inc  = 1'b0;
    mode_leds = MODE_INPUT;
    case (r_state)
      S_INPUT: begin
        if (w_press && is_legal && !w_full) begin
          w_en     = 1'b1;
          play_clr = 1'b1;
        end
      end
      S_PLAYBACK: begin
        mode_leds = MODE_PLAYBACK;
        if (w_term) begin
          if (play_last) rep_clr  = 1'b1;
          else           play_inc = 1'b1;
        end
      end
      S_REPEAT: begin
        mode_leds = MODE_REPEAT;
        select    = SEL_REPEAT;
        if (w_press) begin
          if (!input_eq_pattern) done_clr = 1'b1;
          else if (!rep_last)    rep_inc  = 1'b1;
          else if (w_full)       done_clr = 1'b1;
        end
      end
      S_DONE: begin
        mode_leds = MODE_DONE;
        select    = SEL_DONE;
        if (w_term) begin
          if (done_last) done_clr = 1'b1;
          else           done_inc = 1'b1;
        end
      end
      default: mode_leds = MODE_INPUT;
    endcase
    // Reset masks every strobe except the count clear, whatever the state.
    if (rst) begin
      w_en      = 1'b0;
      clrcount  = 1'b1;
      select    = SEL_PLAYBACK;
      play_clr  = 1'b0;
      play_inc  = 1'b0;
      rep_clr   = 1'b0;
      rep_inc   = 1'b0;
      done_clr  = 1'b0;
      done_inc  = 1'b0;
      mode_leds = MODE_INPUT;
    end
  end

  assign win = r_win;

endmodule

// File: tb/tb_simon_control.sv
// Self-checking bench for simon_control: directed phase walks plus a
// randomized soak, all checked against a cycle-level behavioural model.
module tb_simon_control;

  localparam int DISP  = 4;
  localparam int DEPTH = 2;

  localparam int B_WEN = 7, B_CLR = 6, B_PCLR = 5, B_PINC = 4;
  localparam int B_RCLR = 3, B_RINC = 2, B_DCLR = 1, B_DINC = 0;

  localparam int PH_IN = 0, PH_PLAY = 1, PH_REP = 2, PH_DONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       is_legal;
  logic       input_eq_pattern;
  logic       play_last;
  logic       rep_last;
  logic       done_last;
  logic       w_en;
  logic       clrcount;
  logic [1:0] select;
  logic       play_clr;
  logic       play_inc;
  logic       rep_clr;
  logic       rep_inc;
  logic       done_clr;
  logic       done_inc;
  logic [2:0] mode_leds;
  logic       win;

  simon_control #(.DISP_CYCLES(DISP), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .btn              (btn),
    .is_legal         (is_legal),
    .input_eq_pattern (input_eq_pattern),
    .play_last        (play_last),
    .rep_last         (rep_last),
    .done_last        (done_last),
    .w_en             (w_en),
    .clrcount         (clrcount),
    .select           (select),
    .play_clr         (play_clr),
    .play_inc         (play_inc),
    .rep_clr          (rep_clr),
    .rep_inc          (rep_inc),
    .done_clr         (done_clr),
    .done_inc         (done_inc),
    .mode_leds        (mode_leds),
    .win              (win)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model: phase, display timer, stored count, win flag and
  // the three most recent button samples.
  int   m_phase = PH_IN;
  int   m_timer = 0;
  int   m_cnt   = 0;
  bit   m_win   = 1'b0;
  bit   h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  logic [7:0] g_strb;
  logic [2:0] g_mode;
  logic [1:0] g_sel;
  logic       g_win;
  int         ev [8];

  task automatic clr_ev();
    for (int b = 0; b < 8; b++) ev[b] = 0;
  endtask

  // One clock cycle: compare at negedge+1, advance model at posedge.
  task automatic tick();
    bit         press, term, full;
    logic [7:0] e_strb;
    logic [2:0] e_mode;
    logic [1:0] e_sel;
    int         n_phase, n_timer, n_cnt;
    bit         n_win;
    #1;
    press   = h2 & ~h3;
    term    = (m_timer == DISP - 1);
    full    = (m_cnt == DEPTH);
    e_strb  = '0;
    e_mode  = 3'b001;
    e_sel   = 2'b00;
    n_phase = m_phase;
    n_timer = 0;
    n_cnt   = m_cnt;
    n_win   = m_win;
    case (m_phase)
      PH_IN: begin
        if (press && is_legal && !full) begin
          e_strb[B_WEN]  = 1'b1;
          e_strb[B_PCLR] = 1'b1;
          n_cnt   = m_cnt + 1;
          n_phase = PH_PLAY;
        end
      end
      PH_PLAY: begin
        e_mode  = 3'b010;
        n_timer = term ? 0 : m_timer + 1;
        if (term && play_last) begin
          e_strb[B_RCLR] = 1'b1;
          n_phase = PH_REP;
        end else if (term) begin
          e_strb[B_PINC] = 1'b1;
        end
      end
      PH_REP: begin
        e_mode = 3'b100;
        e_sel  = 2'b01;
        if (press && !input_eq_pattern) begin
          e_strb[B_DCLR] = 1'b1;
          n_phase = PH_DONE;
        end else if (press && !rep_last) begin
          e_strb[B_RINC] = 1'b1;
        end else if (press && full) begin
          e_strb[B_DCLR] = 1'b1;
          n_win   = 1'b1;
          n_phase = PH_DONE;
        end else if (press) begin
          n_phase = PH_IN;
        end
      end
      default: begin
        e_mode  = 3'b111;
        e_sel   = 2'b10;
        n_timer = term ? 0 : m_timer + 1;
        if (term) begin
          if (done_last) e_strb[B_DCLR] = 1'b1;
          else           e_strb[B_DINC] = 1'b1;
        end
      end
    endcase
    if (rst) begin
      e_strb = 8'b0100_0000;
      e_mode = 3'b001;
      e_sel  = 2'b00;
    end
    g_strb = {w_en, clrcount, play_clr, play_inc, rep_clr, rep_inc, done_clr, done_inc};
    g_mode = mode_leds;
    g_sel  = select;
    g_win  = win;
    check("strobes", g_strb, e_strb);
    check("mode", g_mode, e_mode);
    check("select", g_sel, e_sel);
    check("win", g_win, m_win);
    check("pair_excl", {play_clr & play_inc, rep_clr & rep_inc, done_clr & done_inc}, 3'b000);
    for (int b = 0; b < 8; b++) ev[b] += int'(g_strb[b]);
    @(posedge clk);
    if (rst) begin
      m_phase = PH_IN; m_timer = 0; m_cnt = 0; m_win = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      m_phase = n_phase; m_timer = n_timer; m_cnt = n_cnt; m_win = n_win;
      h3 = h2; h2 = h1; h1 = btn;
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_btn(input int hold, input int gap);
    btn = 1'b1;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_until_mode(input logic [2:0] want, input string tag);
    for (int i = 0; i < 200 && g_mode != want; i++) tick();
    check(tag, g_mode, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pinc_q[$];
    int ev_t[$];
    int ev_k[$];
    int rclr_at, wen_at, wen_cnt, incs;
    logic [2:0] mode_chk;

    rst = 1'b1; btn = 1'b0; is_legal = 1'b0; input_eq_pattern = 1'b0;
    play_last = 1'b0; rep_last = 1'b0; done_last = 1'b0;
    clr_ev();
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_mode", g_mode, 3'b001);

    // Illegal pattern: press must be ignored.
    wen_cnt = 0;
    btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      wen_cnt += int'(g_strb[B_WEN]);
      if (i == 2) btn = 1'b0;
    end
    check("illegal_wen", wen_cnt, 0);
    check("illegal_mode", g_mode, 3'b001);

    // Legal press, then directed playback timing.
    is_legal = 1'b1;
    wen_at = -1; wen_cnt = 0; rclr_at = -1; mode_chk = '0;
    btn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 3) begin btn = 1'b0; mode_chk = g_mode; end
      if (g_strb[B_WEN]) begin wen_cnt++; wen_at = i; end
      if (g_strb[B_PINC]) pinc_q.push_back(i);
      if (g_strb[B_RCLR]) rclr_at = i;
      play_last = (pinc_q.size() >= 2);
    end
    check("wen_latency", wen_at, 2);
    check("wen_count", wen_cnt, 1);
    check("play_mode", mode_chk, 3'b010);
    check("pinc_count", pinc_q.size(), 2);
    check("pinc_first", (pinc_q.size() > 0) ? pinc_q[0] : -1, 6);
    check("pinc_second", (pinc_q.size() > 1) ? pinc_q[1] : -1, 10);
    check("rclr_time", rclr_at, 14);
    check("repeat_mode", g_mode, 3'b100);
    play_last = 1'b0;

    // Correct repeat of three entries returns to INPUT.
    clr_ev();
    input_eq_pattern = 1'b1;
    press_btn(2, 3);
    press_btn(2, 3);
    rep_last = 1'b1;
    press_btn(2, 3);
    rep_last = 1'b0;
    check("rinc_count", ev[B_RINC], 2);
    check("no_done_clr", ev[B_DCLR], 0);
    check("back_to_input", g_mode, 3'b001);

    // Round two: press during playback is dropped, then a miss ends the game.
    press_btn(2, 3);
    clr_ev();
    for (int i = 0; i < 200 && g_mode != 3'b100; i++) begin
      play_last = (i >= 8) && ($urandom_range(0, 2) == 0);
      btn = (i >= 3 && i < 6);
      tick();
    end
    btn = 1'b0; play_last = 1'b0;
    check("to_repeat", g_mode, 3'b100);
    check("play_press_drop", ev[B_RINC] + ev[B_WEN], 0);
    clr_ev();
    input_eq_pattern = 1'b1;
    press_btn(2, 3);
    input_eq_pattern = 1'b0;
    press_btn(2, 3);
    check("miss_rinc", ev[B_RINC], 1);
    check("miss_dclr", ev[B_DCLR], 1);
    check("done_mode", g_mode, 3'b111);
    check("done_sel", g_sel, 2'b10);
    check("lose_win", g_win, 1'b0);

    // DONE replay: done_last on every third entry.
    incs = 0;
    for (int i = 0; i < 24; i++) begin
      done_last = (incs == 2);
      tick();
      if (g_strb[B_DINC]) begin incs++; ev_t.push_back(i); ev_k.push_back(0); end
      if (g_strb[B_DCLR]) begin incs = 0; ev_t.push_back(i); ev_k.push_back(1); end
    end
    done_last = 1'b0;
    check("done_events", ev_t.size(), 6);
    for (int k = 0; k < ev_t.size(); k++) begin
      check("done_kind", ev_k[k], (k % 3 == 2) ? 1 : 0);
      if (k > 0) check("done_gap", ev_t[k] - ev_t[k-1], DISP);
    end

    // Reset, then win with DEPTH entries; held button gives one press.
    rst = 1'b1;
    tick();
    check("rst_strobes", g_strb, 8'b0100_0000);
    rst = 1'b0;
    press_btn(2, 3);
    play_last = 1'b1;
    run_until_mode(3'b100, "win_r1_rep");
    play_last = 1'b0;
    input_eq_pattern = 1'b1; rep_last = 1'b1;
    press_btn(2, 3);
    check("win_r1_input", g_mode, 3'b001);
    clr_ev();
    btn = 1'b1;
    repeat (20) tick();
    btn = 1'b0;
    check("held_one_wen", ev[B_WEN], 1);
    play_last = 1'b1;
    run_until_mode(3'b100, "win_r2_rep");
    play_last = 1'b0;
    press_btn(2, 3);
    rep_last = 1'b0;
    check("win_flag", g_win, 1'b1);
    check("win_mode", g_mode, 3'b111);

    // Reset mid-PLAYBACK.
    rst = 1'b1; tick(); rst = 1'b0;
    press_btn(2, 3);
    repeat (2) tick();
    clr_ev();
    rst = 1'b1;
    tick();
    check("midplay_rst", g_strb, 8'b0100_0000);
    rst = 1'b0;
    tick();
    check("midplay_mode", g_mode, 3'b001);
    check("midplay_quiet", g_strb, 8'b0);
    check("midplay_nowen", ev[B_WEN], 0);

    // Randomized soak against the model.
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      is_legal         = ($urandom_range(0, 3) != 0);
      input_eq_pattern = ($urandom_range(0, 5) != 0);
      play_last        = ($urandom_range(0, 2) == 0);
      rep_last         = ($urandom_range(0, 2) == 0);
      done_last        = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
